// File: rtl/trafficlight_ew.sv
// rtl/trafficlight_ew.sv - East-West traffic light with North-South interlock and emergency hold
//
// Purpose:
//   Runs the East-West half of the intersection cycle: RED_HOLD -> LEFT ->
//   GREEN -> YELLOW -> RED_HOLD. Leaving RED_HOLD waits for the North-South
//   light to show red. If North-South stops showing red while East-West is
//   showing a non-red aspect, East-West drops straight back to RED_HOLD.
//   An emergency parks the light in ALLSTOP. The interrupted state and its
//   counter are then resumed once the emergency clears.
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous active-high reset
//   emergency  in   emergency vehicle present (shared with North-South)
//   ns_red     in   1 = North-South currently shows red only
//   ped_req    in   pedestrian request pulse (TRAFFICLIGHT_EW_PED_WALK_EN only)
//   walk       out  walk lamp during served GREEN (TRAFFICLIGHT_EW_PED_WALK_EN only)
//   out[3:0]   out  [3] left turn, [2] green, [1] yellow, [0] red
//   conflict   out  one-cycle pulse on an interlock violation
//   wait_ns    out  RED_HOLD expired but exit blocked by ns_red=0
//
// Optional feature macro: TRAFFICLIGHT_EW_PED_WALK_EN

module trafficlight_ew #(
    parameter int RED_CYCLES    = 18,
    parameter int LEFT_CYCLES   = 5,
    parameter int GREEN_CYCLES  = 10,
    parameter int YELLOW_CYCLES = 3,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic       ns_red,
`ifdef TRAFFICLIGHT_EW_PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [3:0] out,
    output logic       conflict,
    output logic       wait_ns
);

    typedef enum logic [2:0] {
        RED_HOLD = 3'd0,
        LEFT     = 3'd1,
        GREEN    = 3'd2,
        YELLOW   = 3'd3,
        ALLSTOP  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             saved_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               conflict_q;
    logic               wait_ns_q;
    logic [CNT_W-1:0]   last_cnt;

    // Terminal count of the state currently being timed.
    always_comb begin
        last_cnt = CNT_W'(RED_CYCLES - 1);
        case (state_q)
            LEFT:    last_cnt = CNT_W'(LEFT_CYCLES - 1);
            GREEN:   last_cnt = CNT_W'(GREEN_CYCLES - 1);
            YELLOW:  last_cnt = CNT_W'(YELLOW_CYCLES - 1);
            default: last_cnt = CNT_W'(RED_CYCLES - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RED_HOLD;
            saved_q    <= RED_HOLD;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
            wait_ns_q  <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            wait_ns_q  <= 1'b0;
            if (emergency && state_q != ALLSTOP) begin
                // Counter is left untouched so the interrupted state resumes
                // exactly where it stopped, including a saturated RED_HOLD wait.
                state_q <= ALLSTOP;
                saved_q <= state_q;
            end else begin
                case (state_q)
                    ALLSTOP: begin
                        if (!emergency) begin
                            state_q <= saved_q;
                        end
                    end
                    RED_HOLD: begin
                        if (cnt_q == last_cnt) begin
                            if (ns_red) begin
                                state_q <= LEFT;
                                cnt_q   <= '0;
                            end else begin
                                wait_ns_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    LEFT, GREEN, YELLOW: begin
                        if (!ns_red) begin
                            state_q    <= RED_HOLD;
                            cnt_q      <= '0;
                            conflict_q <= 1'b1;
                        end else if (cnt_q == last_cnt) begin
                            cnt_q <= '0;
                            case (state_q)
                                LEFT:    state_q <= GREEN;
                                GREEN:   state_q <= YELLOW;
                                default: state_q <= RED_HOLD;
                            endcase
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= RED_HOLD;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        out = 4'b0001;
        case (state_q)
            LEFT:    out = 4'b1001;
            GREEN:   out = 4'b0100;
            YELLOW:  out = 4'b0010;
            default: out = 4'b0001;
        endcase
    end

    assign conflict = conflict_q;
    assign wait_ns  = wait_ns_q;

`ifdef TRAFFICLIGHT_EW_PED_WALK_EN
    logic ped_pending_q;
    logic walk_q;
    logic green_entry;

    // Same condition under which the FSM moves LEFT -> GREEN this edge.
    assign green_entry = (state_q == LEFT) && !emergency && ns_red && (cnt_q == last_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else if (green_entry) begin
            walk_q        <= ped_pending_q;
            // A request on the entry edge itself is kept for the next period.
            ped_pending_q <= ped_req;
        end else begin
            ped_pending_q <= ped_pending_q | ped_req;
            // Hold walk across an emergency so it resumes with GREEN.
            if (state_q != GREEN && state_q != ALLSTOP) begin
                walk_q <= 1'b0;
            end
        end
    end

    assign walk = walk_q && (state_q == GREEN);
`endif

endmodule

// File: tb/tb_trafficlight_ew.sv
// tb/tb_trafficlight_ew.sv - directed self-checking bench for trafficlight_ew

module tb_trafficlight_ew;

    logic       clk;
    logic       reset;
    logic       emergency;
    logic       ns_red;
    logic [3:0] out;
    logic       conflict;
    logic       wait_ns;
`ifdef TRAFFICLIGHT_EW_PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] O_RED    = 4'b0001;
    localparam logic [3:0] O_LEFT   = 4'b1001;
    localparam logic [3:0] O_GREEN  = 4'b0100;
    localparam logic [3:0] O_YELLOW = 4'b0010;

    trafficlight_ew dut (
        .clk       (clk),
        .reset     (reset),
        .emergency (emergency),
        .ns_red    (ns_red),
`ifdef TRAFFICLIGHT_EW_PED_WALK_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .out       (out),
        .conflict  (conflict),
        .wait_ns   (wait_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check n consecutive cycles of one aspect with no conflict/wait, advancing each cycle.
    task automatic run(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, out, exp);
            check({tag, "_conflict"}, {3'b0, conflict}, 4'b0);
            check({tag, "_wait"}, {3'b0, wait_ns}, 4'b0);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        emergency = 1'b0;
        ns_red    = 1'b1;
`ifdef TRAFFICLIGHT_EW_PED_WALK_EN
        ped_req   = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;

        // Reset state: RED_HOLD counter 0
        check("reset_out", out, O_RED);
        check("reset_conflict", {3'b0, conflict}, 4'b0);
        check("reset_wait", {3'b0, wait_ns}, 4'b0);

        // Two full 36-cycle periods
        run("p1_red", O_RED, 18);
        run("p1_left", O_LEFT, 5);
        run("p1_green", O_GREEN, 10);
        run("p1_yellow", O_YELLOW, 3);
        run("p2_red", O_RED, 18);

        // Emergency held 7 cycles starting in LEFT counter 2
        run("e7_left_pre", O_LEFT, 2);
        emergency = 1'b1;
        check("e7_left_c2", out, O_LEFT);
        step();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) emergency = 1'b0;
            check("e7_allstop", out, O_RED);
            step();
        end
        run("e7_left_resume", O_LEFT, 3);

        // Single-cycle emergency at GREEN counter 4: one ALLSTOP, GREEN resumes at 4
        run("e1_green_pre", O_GREEN, 4);
        emergency = 1'b1;
        check("e1_green_c4", out, O_GREEN);
        step();
        emergency = 1'b0;
        check("e1_allstop", out, O_RED);
        step();
        run("e1_green_resume", O_GREEN, 6);
        run("e1_yellow", O_YELLOW, 3);

        // Interlock wait at RED_HOLD end: ns_red low for 4 cycles
        run("w_red", O_RED, 17);
        ns_red = 1'b0;
        check("w_red_last", out, O_RED);
        check("w_red_last_wait", {3'b0, wait_ns}, 4'b0);
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) ns_red = 1'b1;
            check("w_wait_out", out, O_RED);
            check("w_wait_flag", {3'b0, wait_ns}, 4'b1);
            step();
        end
        run("w_left", O_LEFT, 5);
        run("w_green", O_GREEN, 10);

        // Interlock fault at YELLOW counter 1
        check("f_yellow_c0", out, O_YELLOW);
        step();
        ns_red = 1'b0;
        check("f_yellow_c1", out, O_YELLOW);
        step();
        ns_red = 1'b1;
        check("f_red_out", out, O_RED);
        check("f_conflict_pulse", {3'b0, conflict}, 4'b1);
        step();
        check("f_conflict_clear", {3'b0, conflict}, 4'b0);
        // Fault restarted RED_HOLD at counter 0; one RED cycle already shown
        run("f_red_rest", O_RED, 17);
        run("f_left", O_LEFT, 5);

        // Reset with emergency mid-GREEN: RED_HOLD counter 0, no ALLSTOP
        run("r_green_pre", O_GREEN, 3);
        reset     = 1'b1;
        emergency = 1'b1;
        step();
        reset     = 1'b0;
        emergency = 1'b0;
        run("r_red", O_RED, 18);
        run("r_left", O_LEFT, 5);
        run("r_green", O_GREEN, 10);

        // Emergency at YELLOW last cycle: transition deferred, last cycle repeats
        run("d_yellow_pre", O_YELLOW, 2);
        emergency = 1'b1;
        check("d_yellow_c2", out, O_YELLOW);
        step();
        emergency = 1'b0;
        check("d_allstop", out, O_RED);
        step();
        check("d_yellow_again", out, O_YELLOW);
        step();
        run("d_red", O_RED, 17);

        // Emergency during RED_HOLD wait: resume saturated, interlock re-applied
        ns_red = 1'b0;
        check("ew_red_last", out, O_RED);
        step();
        emergency = 1'b1;
        check("ew_wait", {3'b0, wait_ns}, 4'b1);
        step();
        emergency = 1'b0;
        ns_red    = 1'b1;
        check("ew_allstop_out", out, O_RED);
        check("ew_allstop_wait", {3'b0, wait_ns}, 4'b0);
        step();
        check("ew_resume_red", out, O_RED);
        step();
        check("ew_left", out, O_LEFT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trafficlight_ew.md
Name: trafficlight_ew

Overview:
East-West traffic light, the opposing direction of the North-South light at the same intersection. It runs the complementary 36-cycle sequence: red for 18 cycles while North-South is active, then 5 cycles of left turn + red, 10 cycles of green and 3 cycles of yellow. It shares the emergency line with the North-South light and takes an interlock input from it. The interlock keeps East-West from showing anything other than red unless North-South is red.

Parameters:
RED_CYCLES, 18, cycles spent in RED_HOLD per period
LEFT_CYCLES, 5, cycles of left turn + red
GREEN_CYCLES, 10, cycles of green
YELLOW_CYCLES, 3, cycles of yellow
CNT_W, 5, counter width; must hold max(*_CYCLES)-1

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
emergency  input  1  emergency vehicle present (shared with North-South light)
ns_red  input  1  1 = North-South light currently showing red only (out==4'b0001)
out  output  4  [3] left turn, [2] green, [1] yellow, [0] red
conflict  output  1  one-cycle pulse: interlock violation detected
wait_ns  output  1  1 = RED_HOLD has expired but exit is blocked by ns_red=0

Behaviour:
- Reset: clk and reset are fixed as decided: one clock, reset is synchronous and active-high. On a posedge with reset=1: state=RED_HOLD, counter=0, saved_state=RED_HOLD, conflict=0, wait_ns=0. reset overrides every other input.
- Moore outputs are decoded from registered state.
  - RED_HOLD: out=0001
  - LEFT: out=1001
  - GREEN: out=0100
  - YELLOW: out=0010
  - ALLSTOP: out=0001
- conflict is a registered pulse.
- Each timed state lasts exactly D cycles. counter runs 0..D-1. On the edge where counter==D-1, go to the next state with counter=0.
- Sequence: RED_HOLD -> LEFT -> GREEN -> YELLOW -> RED_HOLD. The period is 36 cycles at defaults.
- Interlock on RED_HOLD exit: requires counter==RED_CYCLES-1 and ns_red=1.
  - If ns_red=0, stay in RED_HOLD with counter held at RED_CYCLES-1 and wait_ns=1.
  - The exit happens on the first edge where ns_red=1.
- Interlock fault: ns_red=0 sampled in LEFT, GREEN or YELLOW (and emergency=0) -> next state RED_HOLD, counter=0, conflict=1 for one cycle.
- Emergency entry: emergency=1 at an edge while state!=ALLSTOP -> next state ALLSTOP, saved_state<=current state, counter frozen.
- Emergency has priority over the interlock fault and over normal transitions.
- ALLSTOP: stays while emergency=1. On the first edge with emergency=0, state<=saved_state and counter is unchanged. The interrupted state therefore still totals D displayed cycles.
- Single-cycle emergency gives exactly 1 ALLSTOP cycle.
- Emergency at counter==D-1: the transition is deferred. After resume, the state shows its last cycle once more, then transitions.
- Emergency during RED_HOLD wait: saved_state=RED_HOLD and the counter stays saturated. On resume, the interlock check is reapplied.
- No register is X after the first reset. The counter never exceeds D-1 of its state.

Optional Feature:
Macro TRAFFICLIGHT_EW_PED_WALK_EN.
- Defined: adds input ped_req (1 bit) and output walk (1 bit).
  - ped_req pulses latch a pending flag in any state.
  - On entry to GREEN (from LEFT) with the flag set: walk=1 for the entire GREEN interval and the flag clears.
  - walk is forced 0 in ALLSTOP and resumes with GREEN.
  - A ped_req arriving during GREEN is served in the next period.
  - Reset clears the flag and walk.
- Undefined: neither port exists and behaviour is identical to the above.

Test Plan:
1. reset 2 cycles, ns_red=1, emergency=0 -> out=0001 for 18 cycles, 1001 for 5, 0100 for 10, 0010 for 3, then 0001 again; period 36 repeats.
2. emergency pulsed 1 cycle at GREEN counter=4 -> one cycle out=0001, then GREEN resumes at counter=4; GREEN totals 10 green cycles; YELLOW starts 1 cycle late.
3. emergency held 7 cycles during LEFT counter=2 -> 7 cycles out=0001, then LEFT resumes at counter 2 for 3 more cycles.
4. ns_red=0 at the end of RED_HOLD for 4 cycles -> wait_ns=1 for 4 cycles, out=0001; LEFT entered on the edge ns_red rises.
5. ns_red dropped to 0 at YELLOW counter=1 -> next cycle RED_HOLD counter=0, conflict=1 exactly one cycle.
6. reset asserted mid-GREEN together with emergency=1 -> RED_HOLD, counter=0, out=0001, no ALLSTOP entered.
